pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: load-use and HI/LO stalls, exception redirect.
// Define PIPE_CTRL_PERF_EN to enable the stall_cycles performance counter.
module pipe_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_use_d,
   input  logic        md_start_e,
   input  logic        md_div_e,
   input  logic        md_use_d,
   input  logic        exc_req,
   output logic        Stall,
   output logic        flush_e,
   output logic        Req,
   output logic        md_busy,
   output logic [3:0]  md_cnt,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD       = 2'd1,
      EXC_HOLD = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt_nx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= RUN;
         md_cnt <= 4'd0;
      end else begin
         state  <= state_nx;
         md_cnt <= cnt_nx;
      end
   end

   // The counter keeps running through an exception; only RUN may load it.
   always_comb begin
      cnt_nx   = (md_cnt != 4'd0) ? md_cnt - 4'd1 : 4'd0;
      state_nx = state;
      unique case (state)
         RUN: begin
            if (Req) begin
               state_nx = EXC_HOLD;
            end else if (md_start_e) begin
               state_nx = MD;
               cnt_nx   = md_div_e ? 4'd10 : 4'd5;
            end
         end
         MD: begin
            if (Req)
               state_nx = EXC_HOLD;
            else if (md_cnt == 4'd1)
               state_nx = RUN;
         end
         EXC_HOLD: state_nx = (cnt_nx != 4'd0) ? MD : RUN;
         default:  state_nx = RUN;
      endcase
   end

   always_comb begin
      Req     = 1'b0;
      Stall   = 1'b0;
      md_busy = 1'b0;
      if (reset) begin
         md_busy = (md_cnt != 4'd0);
         Req     = exc_req && (state != EXC_HOLD);
         if (!Req && (state != EXC_HOLD))
            Stall = ld_use_d | (md_use_d & (md_busy | md_start_e));
      end
   end

   assign flush_e = Stall;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (!reset)
         perf_q <= 32'd0;
      else if (Stall && (perf_q != 32'hFFFF_FFFF))
         perf_q <= perf_q + 32'd1;
   end

   assign stall_cycles = perf_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule
